lane_scroll_scheduler: RTL

- Schedules falling note blocks for the piano/drum LCD display.
- Accepts note requests through a valid/ready handshake and allocates each one to a free sprite slot.
- Per slot, supplies a horizontal offset and a vertical top position to the per-block draw units, which compare them against hcount/Vcount.
- Once per frame it advances every active block; it retires a block and reports a hit when the block reaches the bottom of the screen.

---
 rtl/lane_scroll_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lane_scroll_scheduler.sv
// Falling note-block scheduler for the piano/drum LCD: allocates sprite slots on request
// and advances every active block once per frame, retiring blocks at the bottom of the screen.
module lane_scroll_scheduler #(
    parameter int NUM_LANES  = 8,
    parameter int LANE_PITCH = 60,
    parameter int SLOTS      = 4,
    parameter int SCREEN_H   = 272,
    parameter int BLOCK_H    = 34,
    parameter int SPEED      = 4
) (
    input  logic                  clk_lcd,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  note_valid,
    input  logic [2:0]            note_lane,
    output logic                  note_ready,
    output logic [SLOTS-1:0]      slot_active,
    output logic [SLOTS*10-1:0]   slot_offset,
    output logic [SLOTS*9-1:0]    slot_vpos,
    output logic                  hit_valid,
    output logic [2:0]            hit_lane,
    output logic                  bad_lane,
    output logic                  frame_overrun
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SLOTS-1:0] active_q, active_d;
    logic [9:0]       offset_q [SLOTS];
    logic [9:0]       offset_d [SLOTS];
    logic [8:0]       vpos_q   [SLOTS];
    logic [8:0]       vpos_d   [SLOTS];
    logic [2:0]       lane_q   [SLOTS];
    logic [2:0]       lane_d   [SLOTS];
    logic             hit_valid_q, hit_valid_d;
    logic [2:0]       hit_lane_q, hit_lane_d;
    logic             bad_lane_q, bad_lane_d;
    logic             overrun_q, overrun_d;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             accept;
    logic [9:0]       nv;

    // Gated by rst so the handshake stays closed while the block is held in reset.
    assign note_ready = !rst && (state_q == IDLE) && !(&active_q);
    assign accept     = note_valid && note_ready;

    // Descending scan so the lowest free index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        active_d    = active_q;
        offset_d    = offset_q;
        vpos_d      = vpos_q;
        lane_d      = lane_q;
        hit_valid_d = 1'b0;
        hit_lane_d  = hit_lane_q;
        bad_lane_d  = 1'b0;
        overrun_d   = overrun_q;
        nv          = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (int'(note_lane) >= NUM_LANES) begin
                        bad_lane_d = 1'b1;
                    end else if (free_found) begin
                        active_d[free_idx] = 1'b1;
                        offset_d[free_idx] = 10'(int'(note_lane) * LANE_PITCH);
                        vpos_d[free_idx]   = '0;
                        lane_d[free_idx]   = note_lane;
                    end
                end
                if (frame_start) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (frame_start) begin
                    overrun_d = 1'b1;
                end
                if (active_q[idx_q]) begin
                    nv = 10'(vpos_q[idx_q]) + 10'(SPEED);
                    if (nv >= 10'(SCREEN_H - BLOCK_H)) begin
                        active_d[idx_q] = 1'b0;
                        vpos_d[idx_q]   = '0;
                        hit_valid_d     = 1'b1;
                        hit_lane_d      = lane_q[idx_q];
                    end else begin
                        vpos_d[idx_q] = nv[8:0];
                    end
                end
                if (idx_q == IDX_W'(SLOTS - 1)) begin
                    state_d = IDLE;
                end
                idx_d = idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_lcd or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            active_q    <= '0;
            hit_valid_q <= 1'b0;
            hit_lane_q  <= '0;
            bad_lane_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                offset_q[i] <= '0;
                vpos_q[i]   <= '0;
                lane_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            hit_valid_q <= hit_valid_d;
            hit_lane_q  <= hit_lane_d;
            bad_lane_q  <= bad_lane_d;
            overrun_q   <= overrun_d;
            offset_q    <= offset_d;
            vpos_q      <= vpos_d;
            lane_q      <= lane_d;
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_pack
        assign slot_offset[10*g +: 10] = offset_q[g];
        assign slot_vpos[9*g +: 9]     = vpos_q[g];
    end

    assign slot_active   = active_q;
    assign hit_valid     = hit_valid_q;
    assign hit_lane      = hit_lane_q;
    assign bad_lane      = bad_lane_q;
    assign frame_overrun = overrun_q;

endmodule
